// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub arbiter slice: opcodes and the
// response record. ADDSUB_ARB_OVF_EN adds the signed-overflow field.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest requester ID the arbiter supports (NREQ up to 8).
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [7:0]          sum;
        logic                crry;
`ifdef ADDSUB_ARB_OVF_EN
        logic                ovf;
`endif
    } rsp_t;

endpackage

// File: rtl/eightbitaddsub.sv
// Shared 8-bit adder/subtractor. ctrl_cin selects subtract (val2 - val1)
// by inverting val1 and injecting a carry-in, so crry is the no-borrow flag.
// ADDSUB_ARB_OVF_EN adds the signed-overflow output.
module eightbitaddsub
    import addsub_pkg::*;
(
    input  logic [7:0] val1,
    input  logic [7:0] val2,
    input  logic       ctrl_cin,
    output logic [7:0] sum,
`ifdef ADDSUB_ARB_OVF_EN
    output logic       ovf,
`endif
    output logic       crry
);

    logic [7:0] w_opnd;
    logic [8:0] w_full;

    // Two's-complement add of val2 and the (optionally inverted) val1.
    always_comb begin
        w_opnd = (ctrl_cin == OP_SUB) ? ~val1 : val1;
        w_full = {1'b0, val2} + {1'b0, w_opnd} + {8'b0, ctrl_cin};
    end

    assign sum  = w_full[7:0];
    assign crry = w_full[8];

`ifdef ADDSUB_ARB_OVF_EN
    logic [7:0] w_low;

    // Carry into bit 7 comes from the low seven bits alone.
    always_comb begin
        w_low = {1'b0, val2[6:0]} + {1'b0, w_opnd[6:0]} + {7'b0, ctrl_cin};
    end

    assign ovf = w_low[7] ^ w_full[8];
`endif

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin priority pick: first set request at or above i_ptr,
// wrapping from NREQ-1 back to 0. Returns one-hot grant and its index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [IDW:0] w_cand;

    // Walk candidates in rotated order; the first valid one wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, i_ptr} + (IDW+1)'(k);
            if (w_cand >= (IDW+1)'(NREQ))
                w_cand = w_cand - (IDW+1)'(NREQ);
            if (!o_any && i_req[w_cand[IDW-1:0]]) begin
                o_any                     = 1'b1;
                o_grant[w_cand[IDW-1:0]]  = 1'b1;
                o_idx                     = w_cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one eightbitaddsub among NREQ requesters. Round-robin grant,
// one registered response slot with valid/ready and zero-skid backpressure.
// ADDSUB_ARB_OVF_EN adds the registered rsp_ovf output.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_op,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_sum,
`ifdef ADDSUB_ARB_OVF_EN
    output logic              rsp_ovf,
`endif
    output logic              rsp_crry
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]      r_state;
    logic [IDW-1:0]  r_rr_ptr;
    rsp_t            r_rsp;
    rsp_t            w_rsp_next;

    logic            w_slot_free;
    logic            w_any;
    logic            w_grant;
    logic [NREQ-1:0] w_grant_oh;
    logic [IDW-1:0]  w_idx;
    logic [7:0]      w_a;
    logic [7:0]      w_b;
    logic            w_op;
    logic [7:0]      w_sum;
    logic            w_crry;
    logic            w_unused_id;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant_oh),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Operand mux steered by the encoded winner.
    always_comb begin
        w_a  = req_a[{w_idx, 3'b000} +: 8];
        w_b  = req_b[{w_idx, 3'b000} +: 8];
        w_op = req_op[w_idx];
    end

`ifdef ADDSUB_ARB_OVF_EN
    logic w_ovf;
`endif

    eightbitaddsub u_alu (
        .val1     (w_a),
        .val2     (w_b),
        .ctrl_cin (w_op),
        .sum      (w_sum),
`ifdef ADDSUB_ARB_OVF_EN
        .ovf      (w_ovf),
`endif
        .crry     (w_crry)
    );

    // Slot can take a new result if empty or being drained this cycle.
    always_comb begin
        w_slot_free     = (r_state == ST_EMPTY) | rsp_ready;
        w_grant         = w_slot_free & w_any;
        req_ready       = w_slot_free ? w_grant_oh : '0;
        w_rsp_next      = r_rsp;
        w_rsp_next.id   = ID_MAX_W'(w_idx);
        w_rsp_next.sum  = w_sum;
        w_rsp_next.crry = w_crry;
`ifdef ADDSUB_ARB_OVF_EN
        w_rsp_next.ovf  = w_ovf;
`endif
    end

    // Response-slot FSM, result register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_rsp    <= '0;
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_state  <= ST_FULL;
            r_rsp    <= w_rsp_next;
            r_rr_ptr <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;
        end else if (w_slot_free) begin
            r_state  <= ST_EMPTY;
        end
    end

    assign rsp_valid   = (r_state == ST_FULL);
    assign rsp_id      = r_rsp.id[IDW-1:0];
    assign rsp_sum     = r_rsp.sum;
    assign rsp_crry    = r_rsp.crry;
    assign w_unused_id = ^r_rsp.id;
`ifdef ADDSUB_ARB_OVF_EN
    assign rsp_ovf     = r_rsp.ovf;
`endif

endmodule
